fetch_buffer: RTL

- Instruction-fetch stage directly downstream of the PC register.
- Holds its own fetch pointer and issues word requests to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small FIFO and presents {pc, instr} pairs to decode over a valid/ready handshake.
- Branch/jump resolution (the same source that drives the PC-select targets) redirects it; in-flight stale responses are discarded.

---
 rtl/fetch_buffer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// Instruction-fetch buffer: credit-limited word requests to imem, in-order response FIFO to decode.
// Optional FETCH_MISALIGN_EN: a misaligned redirect halts fetch and emits one flagged nop entry.
module fetch_buffer #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
`ifdef FETCH_MISALIGN_EN
  output logic        if_misalign,
`endif
  output logic [31:0] if_instr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW-1:0] r_ifq_rd;
  logic [AW-1:0] r_ifq_wr;

  logic [31:0] r_fifo_pc    [DEPTH];
  logic [31:0] r_fifo_instr [DEPTH];
  logic [31:0] r_ifq_pc     [DEPTH];

  logic [CW:0]   w_in_use;
  logic          w_halt;
  logic          w_hs;
  logic          w_drop_rsp;
  logic          w_rsp_push;
  logic          w_mis_push;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_out_next;
  logic [31:0]   w_push_pc;
  logic [31:0]   w_push_instr;
  logic [31:0]   w_redirect_target;

  // Credits cover both buffered entries and requests still in flight, so a response always has a slot.
  assign w_in_use       = {1'b0, r_count} + {1'b0, r_outstanding};
  assign imem_req_valid = !reset && !w_halt && (w_in_use < (CW+1)'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;

  assign w_hs       = imem_req_valid && imem_req_ready;
  assign w_drop_rsp = imem_rsp_valid && (r_drop != '0);
  assign w_rsp_push = imem_rsp_valid && (r_drop == '0) && !redirect_valid;
  assign w_push     = w_rsp_push || w_mis_push;
  assign w_pop      = (r_count != '0) && if_ready && !redirect_valid;
  assign w_out_next = r_outstanding + CW'(w_hs) - CW'(imem_rsp_valid);

  assign w_push_pc    = w_mis_push ? r_fetch_pc : r_ifq_pc[r_ifq_rd];
  assign w_push_instr = w_mis_push ? NOP : imem_rsp_data;

  assign if_valid = (r_count != '0);
  assign if_pc    = if_valid ? r_fifo_pc[r_head]    : 32'h0;
  assign if_instr = if_valid ? r_fifo_instr[r_head] : 32'h0;

`ifdef FETCH_MISALIGN_EN
  logic r_halt;
  logic r_mis_pending;
  logic r_fifo_mis [DEPTH];

  assign w_halt            = r_halt;
  assign w_redirect_target = redirect_pc;
  // While halted nothing new is requested, so drop==0 means every stale response has drained.
  assign w_mis_push        = r_halt && r_mis_pending && (r_drop == '0) && !redirect_valid;
  assign if_misalign       = if_valid && r_fifo_mis[r_head];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_halt        <= 1'b0;
      r_mis_pending <= 1'b0;
    end else if (redirect_valid) begin
      r_halt        <= |redirect_pc[1:0];
      r_mis_pending <= |redirect_pc[1:0];
    end else if (w_mis_push) begin
      r_mis_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mis[r_tail] <= w_mis_push;
    end
  end
`else
  logic w_unused_rpc_low;

  assign w_halt            = 1'b0;
  assign w_mis_push        = 1'b0;
  assign w_redirect_target = {redirect_pc[31:2], 2'b00};
  assign w_unused_rpc_low  = ^redirect_pc[1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_ifq_rd      <= '0;
      r_ifq_wr      <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (imem_rsp_valid) begin
        r_ifq_rd <= r_ifq_rd + 1'b1;
      end
      if (w_hs) begin
        r_ifq_wr <= r_ifq_wr + 1'b1;
      end
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old stream.
        r_count    <= '0;
        r_head     <= '0;
        r_tail     <= '0;
        r_drop     <= w_out_next;
        r_fetch_pc <= w_redirect_target;
      end else begin
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        r_drop  <= r_drop - CW'(w_drop_rsp);
        if (w_push) begin
          r_tail <= r_tail + 1'b1;
        end
        if (w_pop) begin
          r_head <= r_head + 1'b1;
        end
        if (w_hs) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_ifq_pc[r_ifq_wr] <= r_fetch_pc;
    end
    if (w_push) begin
      r_fifo_pc[r_tail]    <= w_push_pc;
      r_fifo_instr[r_tail] <= w_push_instr;
    end
  end

  a_rsp_needs_request : assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (r_outstanding != '0));

endmodule
